// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream burst master and its FIFO.
package axis_pkg;

    localparam int AXIS_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    // Elaboration-time ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_burst_m_if.sv
// AXI-Stream beat channel between the burst master and the downstream slave.
interface axis_burst_m_if
    import axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W
);
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;

    modport master (
        output tvalid,
        output tlast,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tlast,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; pop_data is the head word, valid while !empty.
module axis_sync_fifo
    import axis_pkg::*;
#(
    parameter int DATA_W     = AXIS_DATA_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         aclk,
    input  logic                         areset_n,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [DATA_W-1:0]            pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [clog2(FIFO_DEPTH):0]   level
);
    localparam int AW    = clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == LVL_W'(FIFO_DEPTH));
    assign empty    = (level == '0);
    // A push is refused on full even when a pop frees a slot in the same cycle.
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/axis_burst_m.sv
// Burst master: streams burst_len words from the internal FIFO on AXI-Stream, tlast on the final beat.
module axis_burst_m
    import axis_pkg::*;
#(
    parameter int DATA_W     = AXIS_DATA_W,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 8
) (
    input  logic                       aclk,
    input  logic                       areset_n,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       full,
    output logic [clog2(FIFO_DEPTH):0] level,
    input  logic                       start,
    input  logic [LEN_W-1:0]           burst_len,
    output logic                       busy,
    output logic                       done,
    axis_burst_m_if.master             m_axis
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SEND = SEND;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]        state;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  loaded;
    logic              tvalid_q;
    logic              tlast_q;
    logic [DATA_W-1:0] tdata_q;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_empty;
    logic              handshake;
    logic              load;

    assign handshake = tvalid_q & m_axis.tready;
    // The output register refills only when empty or being drained this cycle.
    assign load = (state == ST_SEND) && !fifo_empty && (loaded < len)
               && (!tvalid_q || handshake);

    axis_sync_fifo #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .aclk     (aclk),
        .areset_n (areset_n),
        .push     (wr_en),
        .push_data(wr_data),
        .pop      (load),
        .pop_data (fifo_data),
        .full     (full),
        .empty    (fifo_empty),
        .level    (level)
    );

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state <= ST_IDLE;
            len   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && (burst_len != '0)) begin
                        state <= ST_SEND;
                        len   <= burst_len;
                        busy  <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (handshake && tlast_q) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output register stage: holds tdata/tlast stable while stalled.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            loaded   <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
        end else begin
            if (state == ST_IDLE) loaded <= '0;
            if (load) begin
                loaded   <= loaded + 1'b1;
                tvalid_q <= 1'b1;
                tdata_q  <= fifo_data;
                tlast_q  <= ((loaded + LEN_W'(1)) == len);
            end else if (handshake) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end
        end
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tdata  = tdata_q;

endmodule

// File: tb/tb_axis_burst_m.sv
// Scoreboard bench for axis_burst_m: pushed words are expected back in order, tlast on each burst's final beat.
module tb_axis_burst_m;
    import axis_pkg::*;

    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 8;
    localparam int LEN_W      = 8;
    localparam int LVL_W      = clog2(FIFO_DEPTH) + 1;

    logic              aclk      = 1'b0;
    logic              areset_n  = 1'b0;
    logic              wr_en     = 1'b0;
    logic [DATA_W-1:0] wr_data   = '0;
    logic              full;
    logic [LVL_W-1:0]  level;
    logic              start     = 1'b0;
    logic [LEN_W-1:0]  burst_len = '0;
    logic              busy;
    logic              done;

    axis_burst_m_if #(.DATA_W(DATA_W)) axis_if ();

    axis_burst_m #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .LEN_W     (LEN_W)
    ) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .level    (level),
        .start    (start),
        .burst_len(burst_len),
        .busy     (busy),
        .done     (done),
        .m_axis   (axis_if)
    );

    always #5 aclk = ~aclk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard state shared by the stimulus and the monitor.
    logic [DATA_W-1:0] sb_q[$];
    int                cur_len = 0;
    int                beats   = 0;
    int                bursts  = 0;
    int                tr_mode = 0;
    bit                mon_en  = 1'b0;
    bit                prev_stall   = 1'b0;
    bit                prev_last    = 1'b0;
    bit                prev_last_hs = 1'b0;
    logic [DATA_W-1:0] prev_data    = '0;
    logic [DATA_W-1:0] exp_word;
    bit                mon_hs;

    // tready: 0 = always high, 1 = toggle, 2 = random
    initial begin
        axis_if.tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (tr_mode)
                0:       axis_if.tready = 1'b1;
                1:       axis_if.tready = ~axis_if.tready;
                default: axis_if.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge aclk) begin
        if (mon_en) begin
            mon_hs = axis_if.tvalid && axis_if.tready;
            if (prev_stall) begin
                check_val("hold_valid", 64'(axis_if.tvalid), 64'd1);
                check_val("hold_data", 64'(axis_if.tdata), 64'(prev_data));
                check_val("hold_last", 64'(axis_if.tlast), 64'(prev_last));
            end
            check_val("done_pulse", 64'(done), 64'(prev_last_hs));
            if (mon_hs) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_underflow", 64'd1, 64'd0);
                end else begin
                    exp_word = sb_q.pop_front();
                    check_val("beat_data", 64'(axis_if.tdata), 64'(exp_word));
                    check_val("beat_last", 64'(axis_if.tlast), 64'(beats + 1 == cur_len));
                end
                beats++;
            end
            if (done) bursts++;
            prev_stall   = axis_if.tvalid && !axis_if.tready;
            prev_data    = axis_if.tdata;
            prev_last    = axis_if.tlast;
            prev_last_hs = mon_hs && axis_if.tlast;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d, input bit acc);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        if (acc) sb_q.push_back(d);
    endtask

    task automatic start_burst(input int len, input bit acc);
        start     = 1'b1;
        burst_len = LEN_W'(len);
        if (acc) begin
            cur_len = len;
            beats   = 0;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        check_val("done_seen", 64'(done), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_tvalid"}, 64'(axis_if.tvalid), 64'd0);
        check_val({tag, "_tlast"}, 64'(axis_if.tlast), 64'd0);
        check_val({tag, "_tdata"}, 64'(axis_if.tdata), 64'd0);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_done"}, 64'(done), 64'd0);
        check_val({tag, "_full"}, 64'(full), 64'd0);
        check_val({tag, "_level"}, 64'(level), 64'd0);
    endtask

    task automatic clear_monitor();
        sb_q.delete();
        prev_stall   = 1'b0;
        prev_last    = 1'b0;
        prev_last_hs = 1'b0;
        beats        = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int b0;
        int k;

        areset_n = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        areset_n = 1'b1;
        clear_monitor();
        mon_en = 1'b1;
        tick();

        // 1: back-to-back beats with tready held high
        for (int i = 0; i < 4; i++) push_word(32'hA1 + 32'(i), 1'b1);
        start_burst(4, 1'b1);
        check_val("t1_busy", 64'(busy), 64'd1);
        check_val("t1_tvalid_e0", 64'(axis_if.tvalid), 64'd0);
        tick();
        check_val("t1_tvalid_e1", 64'(axis_if.tvalid), 64'd1);
        check_val("t1_first", 64'(axis_if.tdata), 64'hA1);
        wait_done(20, n);
        check_val("t1_latency", 64'(n), 64'd4);
        check_val("t1_busy_done", 64'(busy), 64'd0);
        check_val("t1_beats", 64'(beats), 64'd4);
        tick();

        // 2: tready toggling
        tr_mode = 1;
        for (int i = 0; i < 4; i++) push_word(32'hB1 + 32'(i), 1'b1);
        start_burst(4, 1'b1);
        wait_done(40, n);
        check_val("t2_beats", 64'(beats), 64'd4);
        tr_mode = 0;
        tick();

        // 3: underrun mid-burst
        push_word(32'hC1, 1'b1);
        push_word(32'hC2, 1'b1);
        start_burst(4, 1'b1);
        repeat (4) tick();
        check_val("t3_gap_tvalid", 64'(axis_if.tvalid), 64'd0);
        check_val("t3_gap_busy", 64'(busy), 64'd1);
        push_word(32'hC3, 1'b1);
        push_word(32'hC4, 1'b1);
        wait_done(20, n);
        check_val("t3_beats", 64'(beats), 64'd4);
        tick();

        // 4: full FIFO, dropped push, full-length burst under random backpressure
        for (int i = 0; i < FIFO_DEPTH; i++) push_word(32'hD0 + 32'(i), 1'b1);
        check_val("t4_full", 64'(full), 64'd1);
        check_val("t4_level", 64'(level), 64'(FIFO_DEPTH));
        push_word(32'hDEAD, 1'b0);
        check_val("t4_level_drop", 64'(level), 64'(FIFO_DEPTH));
        tr_mode = 2;
        start_burst(FIFO_DEPTH, 1'b1);
        wait_done(100, n);
        check_val("t4_beats", 64'(beats), 64'(FIFO_DEPTH));
        check_val("t4_level_empty", 64'(level), 64'd0);
        check_val("t4_full_clr", 64'(full), 64'd0);
        tr_mode = 0;
        tick();

        // 5: zero length ignored, start during SEND ignored
        b0 = bursts;
        start_burst(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_val("t5_len0_busy", 64'(busy), 64'd0);
            check_val("t5_len0_tvalid", 64'(axis_if.tvalid), 64'd0);
            check_val("t5_len0_done", 64'(done), 64'd0);
            tick();
        end
        for (int i = 0; i < 3; i++) push_word(32'hE1 + 32'(i), 1'b1);
        start_burst(3, 1'b1);
        tick();
        start_burst(2, 1'b0);
        check_val("t5_busy_send", 64'(busy), 64'd1);
        wait_done(20, n);
        check_val("t5_beats", 64'(beats), 64'd3);
        tick();
        check_val("t5_bursts", 64'(bursts), 64'(b0 + 1));
        check_val("t5_idle_busy", 64'(busy), 64'd0);
        check_val("t5_idle_tvalid", 64'(axis_if.tvalid), 64'd0);

        // 6: reset in the middle of a burst
        for (int i = 0; i < 4; i++) push_word(32'hF1 + 32'(i), 1'b1);
        start_burst(4, 1'b1);
        k = 0;
        while (beats < 2 && k < 50) begin
            @(negedge aclk);
            #1;
            k++;
        end
        check_val("t6_reach_beat2", 64'(beats >= 2), 64'd1);
        areset_n = 1'b0;
        mon_en   = 1'b0;
        tick();
        check_idle_outputs("t6_reset");
        areset_n = 1'b1;
        clear_monitor();
        mon_en = 1'b1;
        tick();
        check_val("t6_post_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) push_word(32'h61 + 32'(i), 1'b1);
        start_burst(3, 1'b1);
        wait_done(20, n);
        check_val("t6_beats", 64'(beats), 64'd3);
        tick();
        check_val("t6_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
